// File: rtl/ysyx_22040386_pkg.sv
// Shared definitions for the ysyx_22040386 core slice.
//   XLEN            : architectural register / bus width
//   RESET_PC        : first fetch address after reset
//   ARB_* constants : memory arbiter FSM state encodings (3-bit)
package ysyx_22040386_pkg;

    localparam int          XLEN     = 64;
    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

    localparam logic [2:0] ARB_IDLE     = 3'd0;
    localparam logic [2:0] ARB_IF_REQ   = 3'd1;
    localparam logic [2:0] ARB_IF_RESP  = 3'd2;
    localparam logic [2:0] ARB_MEM_REQ  = 3'd3;
    localparam logic [2:0] ARB_MEM_RESP = 3'd4;

endpackage

// File: rtl/ysyx_22040386_mem_arbiter.sv
// Memory port arbiter between instruction fetch (IF) and load/store (MEM).
// One transaction outstanding at a time; MEM wins unless IF has been passed
// over STARVE_LIMIT times in a row. An IF flush drops the in-flight fetch
// response while still letting the bus transaction complete.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ARB_IDLE     | no transaction; arbitrate, pulse gnt, latch winner request
// ARB_IF_REQ   | fetch request presented on bus, waiting for i_BUS_ready
// ARB_IF_RESP  | fetch accepted, waiting for i_BUS_rvalid
// ARB_MEM_REQ  | load/store presented on bus, waiting for i_BUS_ready
// ARB_MEM_RESP | load/store accepted, waiting for i_BUS_rvalid
//
// Ports:
//   i_ARB_clk, i_ARB_rst          clock, async active-high reset
//   i_IF_*  / o_IF_*              fetch request, flush, grant, response
//   i_MEM_* / o_MEM_*             load/store request, grant, response
//   o_BUS_* / i_BUS_*             memory bus request and response
module ysyx_22040386_mem_arbiter
    import ysyx_22040386_pkg::*;
#(
    parameter int ADDR_W       = XLEN,
    parameter int DATA_W       = XLEN,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                i_ARB_clk,
    input  logic                i_ARB_rst,
    input  logic                i_IF_req,
    input  logic [ADDR_W-1:0]   i_IF_addr,
    input  logic                i_IF_flush,
    output logic                o_IF_gnt,
    output logic                o_IF_rvalid,
    output logic [DATA_W-1:0]   o_IF_rdata,
    input  logic                i_MEM_req,
    input  logic                i_MEM_we,
    input  logic [ADDR_W-1:0]   i_MEM_addr,
    input  logic [DATA_W-1:0]   i_MEM_wdata,
    input  logic [DATA_W/8-1:0] i_MEM_wmask,
    output logic                o_MEM_gnt,
    output logic                o_MEM_rvalid,
    output logic [DATA_W-1:0]   o_MEM_rdata,
    output logic                o_BUS_valid,
    input  logic                i_BUS_ready,
    output logic [ADDR_W-1:0]   o_BUS_addr,
    output logic                o_BUS_we,
    output logic [DATA_W-1:0]   o_BUS_wdata,
    output logic [DATA_W/8-1:0] o_BUS_wmask,
    input  logic                i_BUS_rvalid,
    input  logic [DATA_W-1:0]   i_BUS_rdata
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic [2:0]          state;
    logic [2:0]          state_nxt;
    logic                drop;
    logic [3:0]          starve_cnt;
    logic [ADDR_W-1:0]   addr_q;
    logic                we_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wmask_q;

    logic starve_hit;
    logic mem_win;
    logic if_win;

    assign starve_hit = (starve_cnt == STARVE_MAX) && i_IF_req;
    assign mem_win    = (state == ARB_IDLE) && i_MEM_req && !starve_hit;
    assign if_win     = (state == ARB_IDLE) && i_IF_req && !mem_win;

    // Grants are combinational; masking with reset keeps every output at 0
    // while reset is held even if a requester keeps its level high.
    assign o_MEM_gnt = mem_win && !i_ARB_rst;
    assign o_IF_gnt  = if_win && !i_ARB_rst;

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: begin
                if (mem_win)     state_nxt = ARB_MEM_REQ;
                else if (if_win) state_nxt = ARB_IF_REQ;
            end
            ARB_IF_REQ:   if (i_BUS_ready)  state_nxt = ARB_IF_RESP;
            ARB_IF_RESP:  if (i_BUS_rvalid) state_nxt = ARB_IDLE;
            ARB_MEM_REQ:  if (i_BUS_ready)  state_nxt = ARB_MEM_RESP;
            ARB_MEM_RESP: if (i_BUS_rvalid) state_nxt = ARB_IDLE;
            default:                        state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge i_ARB_clk or posedge i_ARB_rst) begin
        if (i_ARB_rst) begin
            state      <= ARB_IDLE;
            drop       <= 1'b0;
            starve_cnt <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= '0;
        end else begin
            state <= state_nxt;

            if (mem_win) begin
                addr_q  <= i_MEM_addr;
                we_q    <= i_MEM_we;
                wdata_q <= i_MEM_wdata;
                wmask_q <= i_MEM_wmask;
            end else if (if_win) begin
                addr_q  <= i_IF_addr;
                we_q    <= 1'b0;
                wdata_q <= '0;
                wmask_q <= '0;
            end

            if (if_win)
                starve_cnt <= '0;
            else if (mem_win && i_IF_req && starve_cnt != STARVE_MAX)
                starve_cnt <= starve_cnt + 4'd1;

            // Clearing on the way into IDLE has priority, so a flush that
            // coincides with the final response only suppresses that response.
            if (state_nxt == ARB_IDLE)
                drop <= 1'b0;
            else if (i_IF_flush && (state == ARB_IF_REQ || state == ARB_IF_RESP))
                drop <= 1'b1;
        end
    end

    assign o_BUS_valid = (state == ARB_IF_REQ) || (state == ARB_MEM_REQ);
    assign o_BUS_addr  = addr_q;
    assign o_BUS_we    = we_q;
    assign o_BUS_wdata = wdata_q;
    assign o_BUS_wmask = wmask_q;

    assign o_IF_rvalid  = (state == ARB_IF_RESP) && i_BUS_rvalid && !drop && !i_IF_flush;
    assign o_IF_rdata   = o_IF_rvalid ? i_BUS_rdata : '0;
    assign o_MEM_rvalid = (state == ARB_MEM_RESP) && i_BUS_rvalid;
    assign o_MEM_rdata  = (o_MEM_rvalid && !we_q) ? i_BUS_rdata : '0;

endmodule
